fpu_issue_scheduler: RTL
========================

# fpu_issue_scheduler

Issue controller that shares the single FPU between `NUM_REQ` instruction requesters (shader threads with private register files). Each cycle it picks at most one hazard-free instruction by round-robin and issues it to the FPU. It tracks every in-flight destination through the pipelined short path (execute, writeback) and the non-pipelined long path (divide/sqrt). It also arbitrates the single FPU writeback port so that short and long results never collide.

## Interface
- `WIDTH`, 32: instruction width.
- `NUM_REQ`, 2: number of requesters; legal range 2–8.
- `LONG_LAT`, 8: long-op latency in cycles, issue to writeback; must be ≥3.
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in `NUM_REQ`: per-requester instruction valid.
- `req_instr_i` in `NUM_REQ*WIDTH`: requester i's instruction in bits `[i*WIDTH +: WIDTH]`.
- `req_ready_o` out `NUM_REQ`: one-hot grant; a transfer happens when valid & ready.
- `fpu_issue_o` out 1: an instruction enters the FPU this cycle.
- `fpu_instr_o` out `WIDTH`: the granted instruction; all zeros when not issuing.
- `fpu_req_o` out `$clog2(NUM_REQ)`: ID of the granted requester.
- `wb_valid_o` out 1: an FPU result is written this cycle.
- `wb_req_o` out `$clog2(NUM_REQ)`: owner of the writeback.
- `wb_dest_o` out 6: destination register of the writeback.

## Operation
- Instruction fields:
  - opcode `[3:0]`, dest `[9:4]`, src1 `[15:10]`, src2 `[21:16]`.
  - Opcodes 4'hA and 4'hB are long ops; all others are short ops.
- Short path, two registered stages:
  - S1 (execute) holds `{valid, req, dest}`.
  - S2 (writeback) copies S1 every cycle.
  - S1 valid is set only on a short issue.
- Long path:
  - State is `{busy, req, dest, cnt}`.
  - On a long issue: busy=1 and cnt=`LONG_LAT-1`.
  - While busy and cnt≠0: cnt decrements each cycle.
  - When busy and cnt==0: the long writeback cycle; busy clears at the end of that cycle.
- Data hazard for requester i: any of src1, src2 or dest equals the dest of a valid S1, valid S2 or busy long entry owned by requester i.
  - This covers RAW and WAW.
  - Entries of other requesters never cause a hazard.
  - Register 0 is not special.
- Structural block:
  - A long op is ineligible while busy=1.
  - A short op is ineligible when busy=1 and cnt==2, because its writeback would land in the long writeback cycle.
- Eligible requester: valid and no hazard and no structural block.
- Arbitration:
  - Round-robin pointer `rr_q`; scan upward from `rr_q`, wrapping modulo `NUM_REQ`, and grant the first eligible requester.
  - After a grant to k, `rr_q` becomes (k+1) mod `NUM_REQ`.
  - With no grant, `rr_q` is unchanged.
- Issue outputs are combinational from inputs and state in the same cycle as the grant.
- Writeback outputs:
  - S2 valid: drive S2's req/dest.
  - Long writeback cycle: drive the long entry's req/dest.
  - Both at once is impossible by construction; the bench asserts it never happens.
  - Otherwise `wb_valid_o`=0, and `wb_req_o`/`wb_dest_o` are 0.
- Requesters not granted must hold their instruction stable; the scheduler does not buffer.

## Timing
- Reset (asynchronous on `rst_ni`=0):
  - S1/S2 valid=0, busy=0, cnt=0, `rr_q`=0.
  - All outputs 0; `req_ready_o`=0.
  - Reset mid-operation discards every in-flight op with no writeback.
- Short op issued in cycle t: writeback at t+2; a dependent op is eligible at t+3 at the earliest.
- Long op issued in cycle t: writeback at t+`LONG_LAT`; a dependent op is eligible at t+`LONG_LAT`+1; the next long op at t+`LONG_LAT`+1.
- Throughput: one issue per cycle when independent ops are available.
- Inputs on the first edge after reset release are honoured; there is no reset-recovery bubble.

## Test plan
- Back-to-back, different requesters: req0 short (dest 5) and req1 short (dest 5), both held valid from reset.
  - Grant req0 at t0 and req1 at t1 (no cross-requester hazard).
  - Writebacks at t2 and t3 with dest 5 and req 0, then 1.
- RAW stall: req0 `fadd` dest 7, then `fmul` with src1=7.
  - The second op issues exactly 3 cycles after the first.
  - `req_ready_o[0]`=0 for the 2 intervening cycles.
- Long/short collision: `LONG_LAT`=8; long op from req0 at t0, independent short ops from req1 offered every cycle.
  - The short op is blocked only at t6.
  - The long writeback occurs at t8, with no double `wb_valid_o`.
  - A second long op (from either requester) is blocked until t9.
- Round-robin fairness: 4 requesters, all always valid and independent, with dests rotating per issue so no requester hazards against its own in-flight ops.
  - Grants cycle 0, 1, 2, 3, 0 …
  - When req2 is made hazardous, the sequence becomes 0, 1, 3, 0, 1, 3.
- WAW: req1 long op dest 9, then short op dest 9.
  - The short op waits until t+`LONG_LAT`+1.
  - The long writeback precedes the short writeback.
- Reset mid-flight: assert `rst_ni`=0 at cycle 4 of a long op with a short op in S1.
  - All outputs drop to 0 immediately.
  - After release, no writeback ever appears for the discarded ops.

Source files
------------

// File: rtl/fpu_issue_scheduler.sv
// rtl/fpu_issue_scheduler.sv - round-robin hazard-aware issue scheduler sharing one FPU
//
// Picks at most one hazard-free instruction per cycle from NUM_REQ requesters
// and tracks in-flight destinations on the short (2-stage) and long
// (LONG_LAT-cycle, non-pipelined) paths. It also keeps the single writeback
// port collision-free.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i            per-requester instruction valid
//   req_instr_i            requester i instruction at [i*WIDTH +: WIDTH]
//   req_ready_o            one-hot grant
//   fpu_issue_o            an instruction enters the FPU this cycle
//   fpu_instr_o            granted instruction (zero when idle)
//   fpu_req_o              granted requester ID
//   wb_valid_o             FPU result written this cycle
//   wb_req_o, wb_dest_o    owner and destination register of the writeback
module fpu_issue_scheduler #(
  parameter  int WIDTH    = 32,
  parameter  int NUM_REQ  = 2,
  parameter  int LONG_LAT = 8,
  localparam int IDW      = $clog2(NUM_REQ),
  localparam int CW       = $clog2(LONG_LAT)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_instr_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     fpu_issue_o,
  output logic [WIDTH-1:0]         fpu_instr_o,
  output logic [IDW-1:0]           fpu_req_o,
  output logic                     wb_valid_o,
  output logic [IDW-1:0]           wb_req_o,
  output logic [5:0]               wb_dest_o
);

  logic           s1_valid_q, s2_valid_q, long_busy_q;
  logic [IDW-1:0] s1_req_q, s2_req_q, long_req_q;
  logic [5:0]     s1_dest_q, s2_dest_q, long_dest_q;
  logic [CW-1:0]  long_cnt_q;
  logic [IDW-1:0] rr_q, rr_d;

  logic [NUM_REQ-1:0] elig;
  logic [3:0]         opc;
  logic [5:0]         dst, sa, sb;
  logic               haz, blk;
  logic               grant_valid;
  logic [IDW-1:0]     grant_idx, scan_idx;
  int                 scan;
  logic [WIDTH-1:0]   g_instr;
  logic               g_long, issue, long_wb;

  function automatic logic touches(logic [5:0] d, logic [5:0] a, logic [5:0] b, logic [5:0] r);
    return (d == r) || (a == r) || (b == r);
  endfunction

  always_comb begin
    elig = '0;
    opc  = '0;
    dst  = '0;
    sa   = '0;
    sb   = '0;
    haz  = 1'b0;
    blk  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      opc = req_instr_i[i*WIDTH +: 4];
      dst = req_instr_i[i*WIDTH+4 +: 6];
      sa  = req_instr_i[i*WIDTH+10 +: 6];
      sb  = req_instr_i[i*WIDTH+16 +: 6];
      // Only this requester's own in-flight entries matter (private register files).
      haz = (s1_valid_q && s1_req_q == IDW'(i) && touches(dst, sa, sb, s1_dest_q)) ||
            (s2_valid_q && s2_req_q == IDW'(i) && touches(dst, sa, sb, s2_dest_q)) ||
            (long_busy_q && long_req_q == IDW'(i) && touches(dst, sa, sb, long_dest_q));
      // A short op issued at cnt==2 would write back in the long writeback cycle.
      blk = (opc == 4'hA || opc == 4'hB) ? long_busy_q
                                         : (long_busy_q && long_cnt_q == CW'(2));
      elig[i] = req_valid_i[i] && !haz && !blk;
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan        = 0;
    scan_idx    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan     = (int'(rr_q) + off) % NUM_REQ;
      scan_idx = IDW'(scan);
      if (!grant_valid && elig[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign g_instr = req_instr_i[int'(grant_idx)*WIDTH +: WIDTH];
  assign g_long  = (g_instr[3:0] == 4'hA) || (g_instr[3:0] == 4'hB);
  // Gated by reset so every output reads zero while rst_ni is low.
  assign issue   = rst_ni && grant_valid;
  assign rr_d    = grant_valid ? IDW'((int'(grant_idx) + 1) % NUM_REQ) : rr_q;

  assign req_ready_o = issue ? (NUM_REQ'(1) << grant_idx) : '0;
  assign fpu_issue_o = issue;
  assign fpu_instr_o = issue ? g_instr : '0;
  assign fpu_req_o   = issue ? grant_idx : '0;

  assign long_wb    = long_busy_q && (long_cnt_q == '0);
  assign wb_valid_o = s2_valid_q || long_wb;
  assign wb_req_o   = s2_valid_q ? s2_req_q  : (long_wb ? long_req_q  : '0);
  assign wb_dest_o  = s2_valid_q ? s2_dest_q : (long_wb ? long_dest_q : '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_req_q    <= '0;
      s1_dest_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_req_q    <= '0;
      s2_dest_q   <= '0;
      long_busy_q <= 1'b0;
      long_req_q  <= '0;
      long_dest_q <= '0;
      long_cnt_q  <= '0;
      rr_q        <= '0;
    end else begin
      s1_valid_q <= issue && !g_long;
      s1_req_q   <= grant_idx;
      s1_dest_q  <= g_instr[9:4];
      s2_valid_q <= s1_valid_q;
      s2_req_q   <= s1_req_q;
      s2_dest_q  <= s1_dest_q;
      if (issue && g_long) begin
        long_busy_q <= 1'b1;
        long_req_q  <= grant_idx;
        long_dest_q <= g_instr[9:4];
        long_cnt_q  <= CW'(LONG_LAT - 1);
      end else if (long_busy_q) begin
        if (long_cnt_q == '0) long_busy_q <= 1'b0;
        else                  long_cnt_q  <= long_cnt_q - CW'(1);
      end
      rr_q <= rr_d;
    end
  end

endmodule
